// File: rtl/cpu_sequencer.sv
// Eight-phase instruction timing for the VeriRISC CPU, with run/halt control and a retired-instruction counter.
// Build option: define SEQ_STEP_EN to add single-instruction stepping through the STEP state.
//
//   state  | meaning
//   IDLE   | after reset; phase held at 0, strobes low
//   RUN    | free-running instruction phases; halts only at the 7->0 boundary
//   STEP   | runs one instruction, then HALTED (SEQ_STEP_EN builds only)
//   HALTED | stopped by the CPU's halt, or after a step; phase held at 0
module cpu_sequencer #(
  parameter int CNT_W     = 16,
  parameter int ALU_PHASE = 6
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             start,
  input  logic             halt,
  input  logic             step,
  input  logic             clr_cnt,
  output logic             fetch,
  output logic             cntrl_clk,
  output logic             alu_clk,
  output logic [2:0]       phase,
  output logic             running,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALTED} state_t;

  localparam logic [2:0] ALU_P = 3'(ALU_PHASE);

  state_t     state, state_nxt;
  logic [2:0] phase_nxt;
  logic       run_now, run_nxt, retire;
  logic       fetch_nxt, cntrl_nxt, alu_nxt;

`ifndef SEQ_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state     <= IDLE;
      phase     <= 3'd0;
      fetch     <= 1'b0;
      cntrl_clk <= 1'b0;
      alu_clk   <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      fetch     <= fetch_nxt;
      cntrl_clk <= cntrl_nxt;
      alu_clk   <= alu_nxt;
      running   <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, HALTED: begin
        if (start && !halt)
          state_nxt = RUN;
`ifdef SEQ_STEP_EN
        else if (step && !halt)
          state_nxt = STEP;
`endif
      end
      RUN:
        if (phase == 3'd7 && halt)
          state_nxt = HALTED;
`ifdef SEQ_STEP_EN
      STEP:
        if (phase == 3'd7)
          state_nxt = HALTED;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode the phase being entered so they switch on the same edge as phase.
  always_comb begin
    run_now   = (state == RUN) || (state == STEP);
    run_nxt   = (state_nxt == RUN) || (state_nxt == STEP);
    phase_nxt = (run_now && run_nxt) ? phase + 3'd1 : 3'd0;
    fetch_nxt = run_nxt && !phase_nxt[2];
    cntrl_nxt = run_nxt && phase_nxt[0];
    alu_nxt   = run_nxt && (phase_nxt == ALU_P);
    retire    = run_now && (phase == 3'd7);
  end

  // Clear takes priority over a coincident retirement; count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)
      instr_cnt <= '0;
    else if (clr_cnt)
      instr_cnt <= '0;
    else if (retire && (instr_cnt != {CNT_W{1'b1}}))
      instr_cnt <= instr_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer; a 16-bit and a 4-bit counter instance share one stimulus.
// Compile with SEQ_STEP_EN defined to exercise the stepping feature.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic start = 1'b0, halt = 1'b0, step = 1'b0, clr_cnt = 1'b0;

  logic        fetch, cntrl_clk, alu_clk, running;
  logic [2:0]  phase;
  logic [15:0] cnt16;
  logic        fetch4, cntrl4, alu4, running4;
  logic [2:0]  phase4;
  logic [3:0]  cnt4;

  cpu_sequencer dut (
    .clk(clk), .rst_(rst_), .start(start), .halt(halt), .step(step), .clr_cnt(clr_cnt),
    .fetch(fetch), .cntrl_clk(cntrl_clk), .alu_clk(alu_clk), .phase(phase),
    .running(running), .instr_cnt(cnt16)
  );

  cpu_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_(rst_), .start(start), .halt(halt), .step(step), .clr_cnt(clr_cnt),
    .fetch(fetch4), .cntrl_clk(cntrl4), .alu_clk(alu4), .phase(phase4),
    .running(running4), .instr_cnt(cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ph;
    logic        f, c, a, r;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   m_ph = 0, m_cnt = 0;
  bit   m_run = 1'b0;
  logic [7:0] fpat = 8'b11110000;
  logic [7:0] cpat = 8'b01010101;
  logic [7:0] apat = 8'b00000010;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.ph   = 3'(m_ph);
    e.r    = m_run;
    e.f    = m_run && fpat[7-m_ph];
    e.c    = m_run && cpat[7-m_ph];
    e.a    = m_run && apat[7-m_ph];
    e.cnt  = 16'(m_cnt);
    e.cnt4 = (m_cnt > 15) ? 4'hf : 4'(m_cnt);
    return e;
  endfunction

  task automatic compare(input exp_t e, input string tag);
    chk({tag, ".phase"},   16'(phase),     16'(e.ph));
    chk({tag, ".fetch"},   16'(fetch),     16'(e.f));
    chk({tag, ".cntrl"},   16'(cntrl_clk), 16'(e.c));
    chk({tag, ".alu"},     16'(alu_clk),   16'(e.a));
    chk({tag, ".running"}, 16'(running),   16'(e.r));
    chk({tag, ".cnt16"},   cnt16,          e.cnt);
    chk({tag, ".cnt4"},    16'(cnt4),      16'(e.cnt4));
    chk({tag, ".phase4"},  16'(phase4),    16'(e.ph));
  endtask

  // run_after: whether the sequencer should be running after this edge (decided by each directed step)
  task automatic cyc(input bit run_after, input string tag = "cyc");
    if (m_run && m_ph == 7) m_cnt++;
    if (clr_cnt) m_cnt = 0;
    m_ph  = (run_after && m_run) ? (m_ph + 1) % 8 : 0;
    m_run = run_after;
    exp_q.push_back(model_exp());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      compare(exp_q.pop_front(), tag);
    end
  endtask

  task automatic stop_at_boundary();
    halt = 1'b1;
    while (m_ph != 7) cyc(1'b1, "to_halt");
    cyc(1'b0, "halted");
    halt = 1'b0;
  endtask

  initial begin
    #12;
    compare(model_exp(), "reset");
    rst_ = 1'b1;
    repeat (2) cyc(1'b0, "idle");

    start = 1'b1;
    cyc(1'b1, "start");
    start = 1'b0;
    for (int k = 1; k <= 24; k++) cyc(1'b1, "run");
    chk("cnt_after_24", cnt16, 16'd3);

    repeat (2) cyc(1'b1, "run");
    halt = 1'b1;
    repeat (5) cyc(1'b1, "halt_pending");
    cyc(1'b0, "halt_edge");
    chk("cnt_halt", cnt16, 16'd4);
    start = 1'b1;
    repeat (2) cyc(1'b0, "start_while_halt");
    halt = 1'b0;

    cyc(1'b1, "restart");
    repeat (5) cyc(1'b1, "start_in_run");
    start = 1'b0;
    #3 rst_ = 1'b0;
    #1;
    m_ph = 0; m_run = 1'b0; m_cnt = 0;
    compare(model_exp(), "async_rst");
    #2 rst_ = 1'b1;
    repeat (3) cyc(1'b0, "post_rst_idle");

    start = 1'b1;
    cyc(1'b1, "sat_start");
    start = 1'b0;
    repeat (159) cyc(1'b1, "sat_run");
    chk("cnt4_saturated", 16'(cnt4), 16'd15);
    clr_cnt = 1'b1;
    cyc(1'b1, "clr_on_retire");
    clr_cnt = 1'b0;
    repeat (11) cyc(1'b1, "post_clr");
    clr_cnt = 1'b1;
    cyc(1'b1, "clr_mid");
    clr_cnt = 1'b0;
    repeat (8) cyc(1'b1, "post_clr2");
    stop_at_boundary();
    clr_cnt = 1'b1;
    cyc(1'b0, "clr_halted");
    clr_cnt = 1'b0;

`ifdef SEQ_STEP_EN
    step = 1'b1;
    cyc(1'b1, "step1_enter");
    step = 1'b0;
    repeat (7) cyc(1'b1, "step1_run");
    cyc(1'b0, "step1_done");
    chk("cnt_step1", cnt16, 16'd1);
    cyc(1'b0, "step1_held");

    step = 1'b1;
    cyc(1'b1, "step2_enter");
    step = 1'b0;
    repeat (7) cyc(1'b1, "step2_run");
    halt = 1'b1;
    cyc(1'b0, "step2_done");
    halt = 1'b0;
    chk("cnt_step2", cnt16, 16'd2);

    start = 1'b1;
    cyc(1'b1, "run_for_step");
    start = 1'b0;
    step = 1'b1;
    repeat (10) cyc(1'b1, "step_in_run");
    step = 1'b0;
    stop_at_boundary();

    start = 1'b1;
    step = 1'b1;
    cyc(1'b1, "collide");
    start = 1'b0;
    step = 1'b0;
    repeat (12) cyc(1'b1, "collide_run");
`else
    step = 1'b1;
    repeat (3) cyc(1'b0, "step_ignored");
    step = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Generates the instruction-phase timing that drives the VeriRISC CPU: `fetch`, `cntrl_clk` and `alu_clk` strobes, all derived from the single system clock.
- Each instruction takes 8 phases. The block also owns run/halt control, stops cleanly at instruction boundaries when the CPU raises `halt`, and counts retired instructions.
- It sits above the CPU top level, between the testbench/system clock and the CPU's timing inputs.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- ALU_PHASE, 6: phase (0-7) in which `alu_clk` is high for one clk cycle.

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst_  input  1  asynchronous active-low reset.
- start  input  1  run request, level-sampled; honoured only in IDLE or HALTED.
- halt  input  1  halt flag from the CPU's control block.
- step  input  1  single-instruction request; active only with SEQ_STEP_EN.
- clr_cnt  input  1  synchronous clear of `instr_cnt`.
- fetch  output  1  high in phases 0-3 (fetch half of the instruction).
- cntrl_clk  output  1  high in odd phases 1, 3, 5, 7.
- alu_clk  output  1  high only in phase ALU_PHASE.
- phase  output  3  current phase, 0-7.
- running  output  1  high in RUN or STEP.
- instr_cnt  output  CNT_W  retired-instruction count, saturating.

Behaviour:
- **States:** IDLE, RUN, STEP, HALTED. Encoding is free.
- **Reset** (rst_ low, asynchronous, any state, including mid-instruction):
  - state=IDLE, phase=0, instr_cnt=0.
  - fetch=0, cntrl_clk=0, alu_clk=0, running=0.
- **Output registration:**
  - All outputs are flop outputs; no combinational path from inputs to outputs.
  - fetch, cntrl_clk and alu_clk are registered decodes of the next phase, so they change on the same edge as `phase`.
- **Not running** (IDLE/HALTED): phase held at 0; fetch, cntrl_clk and alu_clk forced to 0.
- **IDLE/HALTED -> RUN:** when start=1 and halt=0 at an edge.
  - After that edge: phase=0, fetch=1, cntrl_clk=0, running=1.
  - start while halt=1 is ignored; the CPU must be reset first.
- **RUN:** phase increments by 1 each clk, 7 wraps to 0.
- **Instruction retirement:** the 7->0 transition in RUN or STEP retires one instruction.
  - instr_cnt+1, saturating at all-ones (no wrap).
- **RUN -> HALTED:** halt=1 sampled on the edge that would take phase 7->0.
  - That instruction still counts.
  - halt during phases 0-6 has no effect until the phase-7 edge.
- **RUN with start=1:** ignored. start has no effect in RUN or STEP.
- **clr_cnt:**
  - Zeroes instr_cnt on the next edge.
  - If it coincides with a retirement, the clear wins and the result is 0.
  - Works in any state.
- **Full pattern** per instruction, phases 0-7, with ALU_PHASE=6:
  - fetch 11110000
  - cntrl_clk 01010101
  - alu_clk 00000010

Optional Feature:
- **Macro:** SEQ_STEP_EN.
- **Defined:**
  - In IDLE or HALTED with halt=0, step=1 moves to STEP and runs exactly one instruction (phases 0-7).
  - On the 7->0 edge it retires the instruction and goes to HALTED.
  - In HALTED, halt=1 is ignored if it arrives on that edge.
  - start and step together: start wins (RUN).
  - step is ignored in RUN and STEP.
- **Undefined:**
  - The `step` port exists but is ignored and the STEP state is not built.
  - Behaviour is otherwise identical.

Test Plan:
- **Reset and single start:** reset, then start=1 for one cycle, halt=0.
  - phase runs 0..7 repeatedly.
  - fetch/cntrl_clk/alu_clk match 11110000 / 01010101 / 00000010.
  - instr_cnt=3 after 24 cycles.
- **Halt at boundary:** in RUN, raise halt at phase 2 and hold it.
  - Run continues to phase 7, then HALTED with phase=0 and all strobes 0.
  - instr_cnt increments for that instruction; start while halt=1 has no effect.
- **Mid-run reset:** assert rst_ low at phase 5 asynchronously, between clk edges.
  - All outputs go to reset values immediately, instr_cnt=0.
  - On release, the block stays IDLE until start.
- **Saturation and clear:** CNT_W=4, run 20 instructions.
  - instr_cnt=15 held.
  - clr_cnt pulsed coincident with a phase-7 edge gives instr_cnt=0.
- **Single step** (SEQ_STEP_EN): step pulse from IDLE.
  - Exactly 8 phases, instr_cnt=1, then HALTED.
  - A second step gives instr_cnt=2.
  - step during RUN is ignored.
- **Start/step collision** (SEQ_STEP_EN): start=1 and step=1 on the same edge in HALTED.
  - Enters RUN and keeps running past the first instruction.
